// File: rtl/hit_req_pkg.sv
// Shared types and helpers for the hit request latch.
package hit_req_pkg;

    // Per-channel request state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_e;

    // ceil(log2(value)), never less than 1 so a counter always has a bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hit_chan_fsm.sv
// One channel: hit synchronizer, rising-edge detect, request FSM,
// holdoff counter and sticky overflow flag.
//   clk, rst     clock, async active-high reset
//   enable_i     global hit acceptance
//   hit_i        asynchronous discriminator output
//   mask_i       channel mask (new edges ignored)
//   ack_i        this channel has been serviced
//   ovf_clr_i    clear overflow flag
//   req_o        registered request
//   req_d_c      next-state request (combinational)
//   overflow_o   sticky lost-hit flag
import hit_req_pkg::*;

module hit_chan_fsm #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic hit_i,
    input  logic mask_i,
    input  logic ack_i,
    input  logic ovf_clr_i,
    output logic req_o,
    output logic req_d_c,
    output logic overflow_o
);

    localparam int unsigned CNT_W = clog2_min1(HOLDOFF + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    chan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic                   ovf_q, ovf_d;
    logic                   qual_edge_c;

    // Qualified rising edge of the synchronized hit.
    assign qual_edge_c = sync_q[SYNC_STAGES-1] & ~prev_q & enable_i & ~mask_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], hit_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state; an overflow event beats a same-cycle clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ovf_d   = ovf_clr_i ? 1'b0 : ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (qual_edge_c) begin
                    state_d = ST_PEND;
                    req_d   = 1'b1;
                end
            end
            ST_PEND: begin
                // Ack wins over a coincident edge; the edge is reported lost.
                if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
                    cnt_d   = CNT_INIT;
                end
                if (qual_edge_c) begin
                    ovf_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (qual_edge_c) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    assign req_o      = req_q;
    assign req_d_c    = req_d;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/hit_req_latch.sv
// Latches asynchronous per-channel hits as sticky requests for the
// priority encoder, with per-channel holdoff and lost-hit flags.
//   clk, rst   clock, async active-high reset
//   enable     accept new hits
//   hit_in     async hits, one per channel
//   mask       per-channel mask for new edges
//   ack        readout strobe, ack_chan = serviced channel
//   ovf_clr    clear all overflow flags
//   req        registered request vector
//   any_req    registered OR of req, aligned with req
//   overflow   sticky lost-hit flags
import hit_req_pkg::*;

module hit_req_latch #(
    parameter int unsigned SIZE        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [(2**SIZE)-1:0]  hit_in,
    input  logic [(2**SIZE)-1:0]  mask,
    input  logic                  ack,
    input  logic [SIZE-1:0]       ack_chan,
    input  logic                  ovf_clr,
    output logic [(2**SIZE)-1:0]  req,
    output logic                  any_req,
    output logic [(2**SIZE)-1:0]  overflow
);

    localparam int unsigned N = 2**SIZE;

    logic [N-1:0] ack_onehot_c;
    logic [N-1:0] req_d_c;
    logic         any_req_q;

    // Decode the serviced index to a per-channel ack.
    always_comb begin
        ack_onehot_c = '0;
        if (ack) begin
            ack_onehot_c[ack_chan] = 1'b1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        hit_chan_fsm #(
            .SYNC_STAGES (SYNC_STAGES),
            .HOLDOFF     (HOLDOFF)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .enable_i   (enable),
            .hit_i      (hit_in[g]),
            .mask_i     (mask[g]),
            .ack_i      (ack_onehot_c[g]),
            .ovf_clr_i  (ovf_clr),
            .req_o      (req[g]),
            .req_d_c    (req_d_c[g]),
            .overflow_o (overflow[g])
        );
    end

    // Built from next-state req so it updates on the same edge as req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_req_q <= 1'b0;
        end else begin
            any_req_q <= |req_d_c;
        end
    end

    assign any_req = any_req_q;

endmodule

// File: tb/tb_hit_req_latch.sv
module tb_hit_req_latch;

    localparam int unsigned SIZE    = 3;
    localparam int unsigned N       = 8;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned HOLDOFF = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   hit_in;
    logic [N-1:0]   mask;
    logic           ack;
    logic [SIZE-1:0] ack_chan;
    logic           ovf_clr;
    logic [N-1:0]   req;
    logic           any_req;
    logic [N-1:0]   overflow;

    int checks = 0;
    int errors = 0;

    hit_req_latch #(
        .SIZE        (SIZE),
        .SYNC_STAGES (SYNC),
        .HOLDOFF     (HOLDOFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .hit_in   (hit_in),
        .mask     (mask),
        .ack      (ack),
        .ack_chan (ack_chan),
        .ovf_clr  (ovf_clr),
        .req      (req),
        .any_req  (any_req),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: hit history delay line, per-channel pending flag,
    // remaining holdoff cycles and lost-hit flag.
    logic [N-1:0] hist [SYNC+1];
    bit           m_pend [N];
    int           m_hold [N];
    bit           m_ovf  [N];
    logic [N-1:0] m_edge;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_hold[i] = 0;
                m_ovf[i]  = 1'b0;
            end
            for (int j = 0; j <= SYNC; j++) hist[j] = '0;
        end else begin
            m_edge = hist[SYNC-1] & ~hist[SYNC] & {N{enable}} & ~mask;
            for (int i = 0; i < N; i++) begin
                if (ovf_clr) m_ovf[i] = 1'b0;
                if (m_pend[i]) begin
                    if (ack && int'(ack_chan) == i) begin
                        m_pend[i] = 1'b0;
                        m_hold[i] = HOLDOFF;
                    end
                    if (m_edge[i]) m_ovf[i] = 1'b1;
                end else if (m_hold[i] > 0) begin
                    m_hold[i] = m_hold[i] - 1;
                    if (m_edge[i]) m_ovf[i] = 1'b1;
                end else if (m_edge[i]) begin
                    m_pend[i] = 1'b1;
                end
            end
            for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = hit_in;
        end
    end

    function automatic logic [N-1:0] exp_req();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_ovf();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if ($time > 1) begin
            chk("cmp_req", 32'(req), 32'(exp_req()));
            chk("cmp_any_req", 32'(any_req), 32'(|exp_req()));
            chk("cmp_overflow", 32'(overflow), 32'(exp_ovf()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        hit_in = v;
        step(2);
        hit_in = '0;
    endtask

    task automatic do_ack(input int ch);
        ack = 1'b1;
        ack_chan = SIZE'(ch);
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; hit_in = '0; mask = '0;
        ack = 1'b0; ack_chan = '0; ovf_clr = 1'b0;
        #1 rst = 1'b1;
        step(3);
        chk("reset_req", 32'(req), 32'h0);
        chk("reset_any", 32'(any_req), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;

        // 1: latency of three edges
        hit_in = 8'h04;
        step(1); chk("t1_edge1", 32'(req), 32'h0);
        step(1); chk("t1_edge2", 32'(req), 32'h0);
        hit_in = '0;
        step(1);
        chk("t1_req", 32'(req), 32'h04);
        chk("t1_any", 32'(any_req), 32'h1);
        chk("t1_ovf", 32'(overflow), 32'h0);

        // 2: ack, re-hit inside holdoff, re-hit after holdoff
        do_ack(2);
        chk("t2_ack_req", 32'(req), 32'h0);
        chk("t2_ack_any", 32'(any_req), 32'h0);
        pulse(8'h04);
        step(3);
        chk("t2_hold_req", 32'(req), 32'h0);
        chk("t2_hold_ovf", 32'(overflow), 32'h04);
        pulse(8'h04);
        step(1);
        chk("t2_rehit", 32'(req), 32'h04);
        ovf_clr = 1'b1;
        do_ack(2);
        ovf_clr = 1'b0;
        chk("t2_clr_ovf", 32'(overflow), 32'h0);
        step(5);

        // 3: simultaneous channels, ack of non-pending channel
        pulse(8'h81);
        step(1);
        chk("t3_req81", 32'(req), 32'h81);
        do_ack(0);
        chk("t3_ack0", 32'(req), 32'h80);
        do_ack(5);
        chk("t3_ack5", 32'(req), 32'h80);

        // 4: mask, enable, pending survives full mask
        mask = 8'h10;
        pulse(8'h10);
        step(2);
        chk("t4_mask", 32'(req), 32'h80);
        mask = '0; enable = 1'b0;
        pulse(8'h02);
        step(2);
        chk("t4_enable", 32'(req), 32'h80);
        enable = 1'b1; mask = 8'hFF;
        step(2);
        chk("t4_maskff", 32'(req), 32'h80);
        chk("t4_ovf", 32'(overflow), 32'h0);
        mask = '0;
        do_ack(7);
        step(5);

        // 5: edge coincident with ack
        pulse(8'h08);
        step(1);
        chk("t5_pend", 32'(req), 32'h08);
        pulse(8'h08);
        do_ack(3);
        chk("t5_req", 32'(req), 32'h0);
        chk("t5_ovf", 32'(overflow), 32'h08);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("t5_clr", 32'(overflow), 32'h0);
        step(5);

        // 6: async reset mid-holdoff
        pulse(8'h23);
        step(1);
        chk("t6_req23", 32'(req), 32'h23);
        pulse(8'h02);
        step(1);
        chk("t6_ovf", 32'(overflow), 32'h02);
        do_ack(0);
        chk("t6_req22", 32'(req), 32'h22);
        step(1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(req), 32'h0);
        chk("t6_rst_any", 32'(any_req), 32'h0);
        chk("t6_rst_ovf", 32'(overflow), 32'h0);
        step(2);
        rst = 1'b0;
        pulse(8'h40);
        step(1);
        chk("t6_after", 32'(req), 32'h40);
        step(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
